// File: rtl/hsv_core_wb_arbiter.sv
// Writeback arbiter: round-robin pick of one execution-unit result per cycle,
// registered register-file write port plus a one-cycle-late bypass copy.
module hsv_core_wb_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                    clk_core,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    req_valid,
  output logic [NUM_PORTS-1:0]    req_ready,
  input  logic [NUM_PORTS-1:0]    req_rd_we,
  input  logic [NUM_PORTS*5-1:0]  req_rd_addr,
  input  logic [NUM_PORTS*32-1:0] req_rd_data,
  output logic                    wr_en,
  output logic [4:0]              wr_addr,
  output logic [31:0]             wr_data,
  output logic                    byp_valid,
  output logic [4:0]              byp_addr,
  output logic [31:0]             byp_data,
  output logic [63:0]             retire_count
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PW:0] NP = (PW+1)'(NUM_PORTS);
  localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);

  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] w_sel;
  logic [PW-1:0] w_rr_next;
  logic          w_found;
  logic          w_accept;
  logic          w_wr_en;
  logic [4:0]    w_addr_arr [NUM_PORTS];
  logic [31:0]   w_data_arr [NUM_PORTS];

  logic          r_wr_en;
  logic [4:0]    r_wr_addr;
  logic [31:0]   r_wr_data;
  logic          r_byp_valid;
  logic [4:0]    r_byp_addr;
  logic [31:0]   r_byp_data;
  logic [63:0]   r_retire_count;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_unpack
    assign w_addr_arr[k] = req_rd_addr[5*k +: 5];
    assign w_data_arr[k] = req_rd_data[32*k +: 32];
  end

  // Scan ports starting at the round-robin pointer; first valid wins.
  always_comb begin
    logic [PW:0] v_sum;
    v_sum   = '0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      v_sum = {1'b0, r_rr_ptr} + (PW+1)'(i);
      if (v_sum >= NP) v_sum = v_sum - NP;
      if (!w_found && req_valid[v_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = v_sum[PW-1:0];
      end
    end
  end

  assign w_accept  = w_found & ~rst;
  assign w_rr_next = (w_sel == LAST) ? '0 : w_sel + 1'b1;
  assign w_wr_en   = req_rd_we[w_sel] && (w_addr_arr[w_sel] != 5'd0);

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_sel] = 1'b1;
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      r_rr_ptr       <= '0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_byp_valid    <= 1'b0;
      r_byp_addr     <= '0;
      r_byp_data     <= '0;
      r_retire_count <= '0;
    end else begin
      r_wr_en     <= w_accept & w_wr_en;
      r_byp_valid <= r_wr_en;
      r_byp_addr  <= r_wr_addr;
      r_byp_data  <= r_wr_data;
      if (w_accept) begin
        r_rr_ptr       <= w_rr_next;
        r_wr_addr      <= w_addr_arr[w_sel];
        r_wr_data      <= w_data_arr[w_sel];
        r_retire_count <= r_retire_count + 64'd1;
      end
    end
  end

  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign byp_valid    = r_byp_valid;
  assign byp_addr     = r_byp_addr;
  assign byp_data     = r_byp_data;
  assign retire_count = r_retire_count;

endmodule
